// File: rtl/matrix_host_inventory_if.sv
// matrix_host_inventory_if: Tx command handshake and Rx reply bus between the inventory engine (master) and the PHY (slave).
interface matrix_host_inventory_if;
  logic t_CmdReq;
  logic [1:0] t_CmdType;
  logic [15:0] t_CmdRN16;
  logic t_CmdDone;
  logic r_RxValid;
  logic r_RxErr;
  logic [15:0] r_RxData;
  modport master(output t_CmdReq, t_CmdType, t_CmdRN16, input t_CmdDone, r_RxValid, r_RxErr, r_RxData);
  modport slave(input t_CmdReq, t_CmdType, t_CmdRN16, output t_CmdDone, r_RxValid, r_RxErr, r_RxData);
endinterface

// File: rtl/matrix_host_inventory.sv
// matrix_host_inventory: EPC Gen2 host inventory round engine (Query / RN16 / ACK / EPC / NAK / QueryRep).
// Define MAT_HINV_STATS_EN to implement the tag and collision counters.
module matrix_host_inventory #(
  parameter int Tp = 1,
  parameter int T1_TIMEOUT = 64
) (
  input  logic Clk,
  input  logic Reset,
  input  logic h_StartHInvRound,
  output logic h_EndHinvRound,
  input  logic [3:0] h_Q,
  output logic h_EpcValid,
  output logic [7:0] h_TagCount,
  output logic [7:0] h_CollCount,
  output logic [3:0] h_InvState,
  matrix_host_inventory_if.master phy
);
  if (Tp < 0 || T1_TIMEOUT < 2 || T1_TIMEOUT > 65535) begin : gBadParam
    $error("matrix_host_inventory: parameter out of range");
  end

  typedef enum logic [3:0] {
    IDLE, QUERY, WAIT_RN16, ACK, WAIT_EPC, NAK, NEXT, REP, DONE
  } state_t;

  state_t state, nextState;
  logic startPrev;
  logic [15:0] rn16, slotRemain, timer;
  logic startEdge, inWait, timeout, rxGood, rxBad, abort;

  assign startEdge = h_StartHInvRound & ~startPrev;
  assign inWait = state == WAIT_RN16 || state == WAIT_EPC;
  assign timeout = timer == 16'(T1_TIMEOUT - 1);
  assign rxGood = phy.r_RxValid & ~phy.r_RxErr;
  assign rxBad = phy.r_RxValid & phy.r_RxErr;
  assign abort = ~h_StartHInvRound;

  always_ff @(posedge Clk)
    if (Reset) state <= IDLE;
    else state <= nextState;

  // Command states always finish their handshake before honouring an abort.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      nextState = startEdge ? QUERY : IDLE;
      QUERY:     if (phy.t_CmdDone) nextState = abort ? IDLE : WAIT_RN16;
      ACK:       if (phy.t_CmdDone) nextState = abort ? IDLE : WAIT_EPC;
      NAK:       if (phy.t_CmdDone) nextState = abort ? IDLE : NEXT;
      REP:       if (phy.t_CmdDone) nextState = abort ? IDLE : WAIT_RN16;
      WAIT_RN16: nextState = abort ? IDLE : rxGood ? ACK : (rxBad || timeout) ? NEXT : WAIT_RN16;
      WAIT_EPC:  nextState = abort ? IDLE : rxGood ? NEXT : (rxBad || timeout) ? NAK : WAIT_EPC;
      NEXT:      nextState = abort ? IDLE : (slotRemain == 16'd1) ? DONE : REP;
      DONE:      nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    phy.t_CmdReq = state == QUERY || state == ACK || state == NAK || state == REP;
    phy.t_CmdType = state == ACK ? 2'b10 : state == NAK ? 2'b11 : state == REP ? 2'b01 : 2'b00;
    phy.t_CmdRN16 = state == ACK ? rn16 : 16'h0;
    h_EndHinvRound = state == DONE;
    h_InvState = state;
  end

  // The timer restarts whenever a wait state is (re)entered and counts while it stays.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      startPrev <= 1'b0;
      rn16 <= '0;
      slotRemain <= '0;
      timer <= '0;
      h_EpcValid <= 1'b0;
    end else begin
      startPrev <= h_StartHInvRound;
      timer <= (inWait && nextState == state) ? timer + 16'd1 : '0;
      h_EpcValid <= state == WAIT_EPC && !abort && rxGood;
      if (state == WAIT_RN16 && !abort && rxGood) rn16 <= phy.r_RxData;
      if (state == IDLE && startEdge) slotRemain <= 16'd1 << h_Q;
      else if (state == NEXT && !abort && slotRemain != 16'd1) slotRemain <= slotRemain - 16'd1;
    end
  end

`ifdef MAT_HINV_STATS_EN
  logic [7:0] tagCnt, collCnt;
  always_ff @(posedge Clk) begin
    if (Reset || (state == IDLE && startEdge)) begin
      tagCnt <= '0;
      collCnt <= '0;
    end else begin
      if (state == WAIT_EPC && !abort && rxGood && tagCnt != 8'hff) tagCnt <= tagCnt + 8'd1;
      if (inWait && !abort && rxBad && collCnt != 8'hff) collCnt <= collCnt + 8'd1;
    end
  end
  assign h_TagCount = tagCnt;
  assign h_CollCount = collCnt;
`else
  assign h_TagCount = 8'd0;
  assign h_CollCount = 8'd0;
`endif
endmodule

// File: tb/tb_matrix_host_inventory.sv
// tb_matrix_host_inventory: randomized inventory rounds checked against a slot-level reference model.
module tb_matrix_host_inventory;
  localparam int T1 = 64;
  localparam logic [1:0] C_QUERY = 2'b00, C_REP = 2'b01, C_ACK = 2'b10, C_NAK = 2'b11;
`ifdef MAT_HINV_STATS_EN
  localparam bit statsEn = 1'b1;
`else
  localparam bit statsEn = 1'b0;
`endif

  logic Clk = 1'b0, Reset = 1'b1, h_StartHInvRound = 1'b0;
  logic [3:0] h_Q = 4'd0;
  logic h_EndHinvRound, h_EpcValid;
  logic [7:0] h_TagCount, h_CollCount;
  logic [3:0] h_InvState;
  int tests = 0, fails = 0, epcPulses = 0;
  int kindQ[$];
  logic [15:0] rnQ[$];

  matrix_host_inventory_if phy();

  matrix_host_inventory #(.T1_TIMEOUT(T1)) dut (
    .Clk(Clk), .Reset(Reset), .h_StartHInvRound(h_StartHInvRound), .h_EndHinvRound(h_EndHinvRound),
    .h_Q(h_Q), .h_EpcValid(h_EpcValid), .h_TagCount(h_TagCount), .h_CollCount(h_CollCount),
    .h_InvState(h_InvState), .phy(phy)
  );

  always #5 Clk = ~Clk;
  always @(negedge Clk) if (h_EpcValid === 1'b1) epcPulses++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] sat(input int v);
    return statsEn ? ((v > 255) ? 8'd255 : 8'(v)) : 8'd0;
  endfunction

  task automatic do_reset();
    Reset = 1'b1; h_StartHInvRound = 1'b0;
    phy.t_CmdDone = 1'b0; phy.r_RxValid = 1'b0; phy.r_RxErr = 1'b0; phy.r_RxData = 16'h0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // Waits for the next command, checks it and completes the Tx handshake.
  task automatic serve_cmd(input logic [1:0] expType, input logic [15:0] expRn, input string name);
    int n = 0;
    while (!(phy.t_CmdReq === 1'b1 || h_EndHinvRound === 1'b1) && n < 300) begin @(negedge Clk); n++; end
    tests++;
    if (phy.t_CmdReq !== 1'b1 || phy.t_CmdType !== expType || phy.t_CmdRN16 !== (expType == C_ACK ? expRn : 16'h0)) begin
      fails++;
      $display("FAIL %s cmd: req=%b type=%0d rn16=%h, required req=1 type=%0d rn16=%h", name,
               phy.t_CmdReq, phy.t_CmdType, phy.t_CmdRN16, expType, (expType == C_ACK ? expRn : 16'h0));
    end
    repeat ($urandom_range(0, 3)) begin
      @(negedge Clk);
      tests++;
      if (phy.t_CmdReq !== 1'b1 || phy.t_CmdType !== expType) begin
        fails++;
        $display("FAIL %s hold: req=%b type=%0d, required req=1 type=%0d", name, phy.t_CmdReq, phy.t_CmdType, expType);
      end
    end
    phy.t_CmdDone = 1'b1;
    @(negedge Clk);
    phy.t_CmdDone = 1'b0;
    tests++;
    if (phy.t_CmdReq !== 1'b0) begin
      fails++;
      $display("FAIL %s drop: req=%b, required 0", name, phy.t_CmdReq);
    end
  endtask

  task automatic send_rx(input logic err, input logic [15:0] data, input int d);
    repeat (d) @(negedge Clk);
    phy.r_RxValid = 1'b1; phy.r_RxErr = err; phy.r_RxData = data;
    @(negedge Clk);
    phy.r_RxValid = 1'b0; phy.r_RxErr = 1'b0; phy.r_RxData = 16'($urandom);
  endtask

  task automatic expect_silence(input int expK, input string name);
    int k = 0;
    while (!(phy.t_CmdReq === 1'b1 || h_EndHinvRound === 1'b1) && k < 300) begin @(negedge Clk); k++; end
    tests++;
    if (k != expK) begin
      fails++;
      $display("FAIL %s wait length: got %0d cycles, required %0d", name, k, expK);
    end
  endtask

  task automatic watch_quiet(input int cycles, input string name);
    int bad = 0;
    repeat (cycles) begin
      @(negedge Clk);
      if (phy.t_CmdReq !== 1'b0 || h_EndHinvRound !== 1'b0 || h_EpcValid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d active cycles, required 0", name, bad);
    end
  endtask

  function automatic int pick_delay(input int maxDly);
    return (maxDly > 0 && $urandom_range(0, 7) == 0) ? T1 - 1 : int'($urandom_range(0, maxDly));
  endfunction

  // Slot kinds: 0 empty, 1 RN16 error, 2 good EPC, 3 EPC error, 4 EPC timeout.
  task automatic run_round(input int q, input int maxDly, input int forceKind, input bit keepHigh, input string name);
    int tags = 0, colls = 0, pulses0, kind = 0, d, n = 0;
    logic [15:0] rn;
    pulses0 = epcPulses;
    h_Q = 4'(q); h_StartHInvRound = 1'b0;
    @(negedge Clk);
    h_StartHInvRound = 1'b1;
    @(negedge Clk);
    h_Q = 4'($urandom);
    tests++;
    if (phy.t_CmdReq !== 1'b1 || h_TagCount !== 8'd0 || h_CollCount !== 8'd0) begin
      fails++;
      $display("FAIL %s start: req=%b tag=%0d coll=%0d, required 1/0/0", name, phy.t_CmdReq, h_TagCount, h_CollCount);
    end
    for (int s = 0; s < (1 << q); s++) begin
      serve_cmd(s == 0 ? C_QUERY : C_REP, 16'h0, name);
      kind = kindQ.size() != 0 ? kindQ.pop_front() : forceKind >= 0 ? forceKind : int'($urandom_range(0, 4));
      rn = rnQ.size() != 0 ? rnQ.pop_front() : 16'($urandom);
      d = pick_delay(maxDly);
      if (kind == 0) expect_silence(T1 + 1, name);
      else if (kind == 1) begin
        send_rx(1'b1, rn, d);
        colls++;
        tests++;
        if (h_CollCount !== sat(colls)) begin
          fails++;
          $display("FAIL %s rn16 coll count: got %0d, required %0d", name, h_CollCount, sat(colls));
        end
      end else begin
        send_rx(1'b0, rn, d);
        serve_cmd(C_ACK, rn, name);
        d = pick_delay(maxDly);
        if (kind == 2) begin
          send_rx(1'b0, 16'($urandom), d);
          tags++;
          tests++;
          if (h_EpcValid !== 1'b1 || h_TagCount !== sat(tags)) begin
            fails++;
            $display("FAIL %s epc: valid=%b tag=%0d, required 1/%0d", name, h_EpcValid, h_TagCount, sat(tags));
          end
        end else begin
          if (kind == 3) begin
            send_rx(1'b1, 16'($urandom), d);
            colls++;
            tests++;
            if (h_CollCount !== sat(colls)) begin
              fails++;
              $display("FAIL %s epc coll count: got %0d, required %0d", name, h_CollCount, sat(colls));
            end
          end else expect_silence(T1, name);
          serve_cmd(C_NAK, 16'h0, name);
        end
      end
    end
    while (h_EndHinvRound !== 1'b1 && n < 300) begin @(negedge Clk); n++; end
    tests++;
    if (n != (kind == 0 ? 0 : 1)) begin
      fails++;
      $display("FAIL %s end latency: got %0d, required %0d", name, n, (kind == 0 ? 0 : 1));
    end
    if (!keepHigh) h_StartHInvRound = 1'b0;
    @(negedge Clk);
    tests++;
    if (h_EndHinvRound !== 1'b0 || h_InvState !== 4'd0 || phy.t_CmdReq !== 1'b0) begin
      fails++;
      $display("FAIL %s after end: end=%b state=%0d req=%b, required 0/0/0", name, h_EndHinvRound, h_InvState, phy.t_CmdReq);
    end
    tests++;
    if (h_TagCount !== sat(tags) || h_CollCount !== sat(colls) || epcPulses - pulses0 != tags) begin
      fails++;
      $display("FAIL %s totals: tag=%0d coll=%0d pulses=%0d, required %0d/%0d/%0d", name,
               h_TagCount, h_CollCount, epcPulses - pulses0, sat(tags), sat(colls), tags);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({h_EndHinvRound, h_EpcValid, h_TagCount, h_CollCount, h_InvState, phy.t_CmdReq, phy.t_CmdType, phy.t_CmdRN16} !== '0) begin
      fails++;
      $display("FAIL reset outputs: end=%b epc=%b tag=%0d coll=%0d state=%0d req=%b type=%0d rn=%h, required all 0",
               h_EndHinvRound, h_EpcValid, h_TagCount, h_CollCount, h_InvState, phy.t_CmdReq, phy.t_CmdType, phy.t_CmdRN16);
    end
  endtask

  task automatic test_single_slot();
    do_reset();
    kindQ = '{2}; rnQ = '{16'hA5A5};
    run_round(0, 20, -1, 1'b0, "q0_single");
  endtask

  task automatic test_empty_slots();
    do_reset();
    kindQ = '{0, 0, 0, 0};
    run_round(2, 20, -1, 1'b0, "q2_empty");
  endtask

  task automatic test_collisions();
    do_reset();
    kindQ = '{1, 3};
    run_round(1, 20, -1, 1'b0, "q1_coll");
  endtask

  task automatic test_random();
    do_reset();
    repeat (6) run_round(int'($urandom_range(0, 3)), 60, -1, 1'b0, "random");
  endtask

  task automatic test_saturation();
    do_reset();
    run_round(9, 0, 2, 1'b0, "sat_tag");
    run_round(9, 0, 1, 1'b0, "sat_coll");
  endtask

  task automatic test_retrigger();
    do_reset();
    kindQ = '{2};
    run_round(0, 10, -1, 1'b1, "hold_first");
    watch_quiet(100, "hold_no_retrigger");
    tests++;
    if (h_TagCount !== sat(1) || h_CollCount !== 8'd0) begin
      fails++;
      $display("FAIL hold counts: tag=%0d coll=%0d, required %0d/0", h_TagCount, h_CollCount, sat(1));
    end
    run_round(0, 10, 1, 1'b0, "second_round");
  endtask

  task automatic test_abort();
    do_reset();
    h_Q = 4'd2; h_StartHInvRound = 1'b1;
    @(negedge Clk);
    serve_cmd(C_QUERY, 16'h0, "abort_wait_query");
    repeat (5) @(negedge Clk);
    h_StartHInvRound = 1'b0;
    @(negedge Clk);
    tests++;
    if (h_InvState !== 4'd0 || phy.t_CmdReq !== 1'b0 || h_EndHinvRound !== 1'b0) begin
      fails++;
      $display("FAIL abort_wait: state=%0d req=%b end=%b, required 0/0/0", h_InvState, phy.t_CmdReq, h_EndHinvRound);
    end
    watch_quiet(100, "abort_wait_quiet");
    h_StartHInvRound = 1'b1;
    @(negedge Clk);
    h_StartHInvRound = 1'b0;
    repeat (3) begin
      tests++;
      if (phy.t_CmdReq !== 1'b1) begin
        fails++;
        $display("FAIL abort_cmd hold: req=%b, required 1", phy.t_CmdReq);
      end
      @(negedge Clk);
    end
    phy.t_CmdDone = 1'b1;
    @(negedge Clk);
    phy.t_CmdDone = 1'b0;
    tests++;
    if (h_InvState !== 4'd0 || phy.t_CmdReq !== 1'b0) begin
      fails++;
      $display("FAIL abort_cmd: state=%0d req=%b, required 0/0", h_InvState, phy.t_CmdReq);
    end
    watch_quiet(100, "abort_cmd_quiet");
  endtask

  task automatic test_reset_mid();
    int pulses0;
    do_reset();
    h_Q = 4'd1; h_StartHInvRound = 1'b1;
    @(negedge Clk);
    serve_cmd(C_QUERY, 16'h0, "rstmid_query");
    send_rx(1'b1, 16'h1234, 1);
    serve_cmd(C_REP, 16'h0, "rstmid_rep");
    send_rx(1'b0, 16'h5A3C, 1);
    serve_cmd(C_ACK, 16'h5A3C, "rstmid_ack");
    repeat (2) @(negedge Clk);
    pulses0 = epcPulses;
    Reset = 1'b1; phy.r_RxValid = 1'b1; phy.r_RxErr = 1'b0;
    @(negedge Clk);
    phy.r_RxValid = 1'b0;
    tests++;
    if ({h_EndHinvRound, h_EpcValid, h_TagCount, h_CollCount, h_InvState, phy.t_CmdReq, phy.t_CmdType, phy.t_CmdRN16} !== '0) begin
      fails++;
      $display("FAIL rstmid outputs: end=%b epc=%b tag=%0d coll=%0d state=%0d req=%b, required all 0",
               h_EndHinvRound, h_EpcValid, h_TagCount, h_CollCount, h_InvState, phy.t_CmdReq);
    end
    @(negedge Clk);
    Reset = 1'b0; h_StartHInvRound = 1'b0;
    @(negedge Clk);
    tests++;
    if (epcPulses != pulses0 || h_InvState !== 4'd0) begin
      fails++;
      $display("FAIL rstmid epc pulses: got %0d state=%0d, required 0/0", epcPulses - pulses0, h_InvState);
    end
  endtask

  initial begin
    test_reset();
    test_single_slot();
    test_empty_slots();
    test_collisions();
    test_random();
    test_saturation();
    test_retrigger();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
